// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU result stage: opcodes, flag bit positions,
// condition codes, buffer state encoding and the buffered entry layout.
package alu_pkg;

    localparam logic [4:0] OP_PASS        = 5'h01;
    localparam logic [4:0] OP_ADD         = 5'h03;
    localparam logic [4:0] OP_SUB         = 5'h04;
    localparam logic [4:0] OP_LOGIC_FIRST = 5'h05;
    localparam logic [4:0] OP_LOGIC_LAST  = 5'h0A;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  rd;
        logic        we;
    } fifo_entry_t;

    function automatic logic op_defined(input logic [4:0] op);
        return (op == OP_PASS) || ((op >= OP_ADD) && (op <= OP_LOGIC_LAST));
    endfunction

    function automatic logic op_full_flags(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_zc_flags(input logic [4:0] op);
        return (op >= OP_LOGIC_FIRST) && (op <= OP_LOGIC_LAST);
    endfunction

    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        n = f[FLAG_N];
        z = f[FLAG_Z];
        c = f[FLAG_C];
        v = f[FLAG_V];
        case (cc)
            CC_EQ:   return z;
            CC_NE:   return !z;
            CC_CS:   return c;
            CC_CC:   return !c;
            CC_MI:   return n;
            CC_PL:   return !n;
            CC_VS:   return v;
            CC_VC:   return !v;
            CC_HI:   return c && !z;
            CC_LS:   return !c || z;
            CC_GE:   return n == v;
            CC_LT:   return n != v;
            CC_GT:   return !z && (n == v);
            CC_LE:   return z || (n != v);
            CC_AL:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry in-order buffer between the ALU and writeback. No pass-through:
// a full buffer refuses pushes even if the head is popped in the same cycle.
module result_fifo2
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  fifo_entry_t in_entry,
    output logic        out_valid,
    input  logic        out_ready,
    output fifo_entry_t out_entry,
    output logic [1:0]  occupancy
);

    buf_state_e  state_q, state_d;
    fifo_entry_t head_q, head_d;
    fifo_entry_t tail_q, tail_d;
    logic        push, pop;

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_entry = head_q;
    assign occupancy = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    head_d  = in_entry;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (push && pop) begin
                    head_d = in_entry;
                end else if (push) begin
                    tail_d  = in_entry;
                    state_d = BUF_FULL;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: opcode decode, flag register and illegal-op pulse around a
// two-entry result buffer. Optional condition evaluator enabled by COND_EVAL_EN.
module alu_result_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic        in_n,
    input  logic        in_z,
    input  logic        in_c,
    input  logic        in_v,
    input  logic [4:0]  in_op,
    input  logic [3:0]  in_rd,
    input  logic        in_set_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_rd,
    output logic        out_we,
    output logic [3:0]  flags,
`ifdef COND_EVAL_EN
    input  logic [3:0]  cond,
    output logic        cond_true,
`endif
    output logic        illegal,
    output logic [1:0]  occupancy
);

    fifo_entry_t in_entry, out_entry;
    logic        accept;
    logic [3:0]  flags_q, flags_d;
    logic        illegal_q, illegal_d;

    assign accept   = in_valid && in_ready;
    assign in_entry = '{data: in_result, rd: in_rd, we: op_defined(in_op)};

    result_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (out_entry),
        .occupancy (occupancy)
    );

    assign out_data = out_entry.data;
    assign out_rd   = out_entry.rd;
    assign out_we   = out_entry.we;

    // Logic ops only touch Z and C; N and V keep the last arithmetic result.
    always_comb begin
        flags_d   = flags_q;
        illegal_d = accept && !op_defined(in_op);
        if (accept && in_set_flags) begin
            if (op_full_flags(in_op)) begin
                flags_d[FLAG_N] = in_n;
                flags_d[FLAG_Z] = in_z;
                flags_d[FLAG_C] = in_c;
                flags_d[FLAG_V] = in_v;
            end else if (op_zc_flags(in_op)) begin
                flags_d[FLAG_Z] = in_z;
                flags_d[FLAG_C] = in_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    assign flags   = flags_q;
    assign illegal = illegal_q;

`ifdef COND_EVAL_EN
    assign cond_true = cond_eval(cond, flags_q);
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a vector table for single words plus
// hand sequences for back-pressure, full-buffer and reset corners.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic        in_n = 1'b0, in_z = 1'b0, in_c = 1'b0, in_v = 1'b0;
    logic [4:0]  in_op = '0;
    logic [3:0]  in_rd = '0;
    logic        in_set_flags = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_rd;
    logic        out_we;
    logic [3:0]  flags;
    logic        illegal;
    logic [1:0]  occupancy;
`ifdef COND_EVAL_EN
    logic [3:0]  cond = '0;
    logic        cond_true;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_n         (in_n),
        .in_z         (in_z),
        .in_c         (in_c),
        .in_v         (in_v),
        .in_op        (in_op),
        .in_rd        (in_rd),
        .in_set_flags (in_set_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .flags        (flags),
`ifdef COND_EVAL_EN
        .cond         (cond),
        .cond_true    (cond_true),
`endif
        .illegal      (illegal),
        .occupancy    (occupancy)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] result;
        logic [3:0]  nzcv;
        logic        sf;
        logic [3:0]  rd;
        logic        exp_we;
        logic [3:0]  exp_flags;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] res, input logic [3:0] nzcv,
                         input logic sf, input logic [3:0] rd);
        in_valid     = 1'b1;
        in_op        = op;
        in_result    = res;
        {in_n, in_z, in_c, in_v} = nzcv;
        in_set_flags = sf;
        in_rd        = rd;
    endtask

    initial begin
        logic [15:0] cc_exp;

        vecs[0]  = '{5'h03, 32'h0000_0000, 4'b0110, 1'b1, 4'h1, 1'b1, 4'b0110, 1'b0};
        vecs[1]  = '{5'h01, 32'h1234_5678, 4'b1111, 1'b1, 4'h2, 1'b1, 4'b0110, 1'b0};
        vecs[2]  = '{5'h0B, 32'hDEAD_BEEF, 4'b1001, 1'b1, 4'h3, 1'b0, 4'b0110, 1'b1};
        vecs[3]  = '{5'h04, 32'hFFFF_FFFF, 4'b1000, 1'b1, 4'h4, 1'b1, 4'b1000, 1'b0};
        vecs[4]  = '{5'h05, 32'h0000_0000, 4'b0001, 1'b1, 4'h5, 1'b1, 4'b1000, 1'b0};
        vecs[5]  = '{5'h06, 32'h0000_00FF, 4'b0111, 1'b0, 4'h6, 1'b1, 4'b1000, 1'b0};
        vecs[6]  = '{5'h0A, 32'hA5A5_A5A5, 4'b0110, 1'b1, 4'h7, 1'b1, 4'b1110, 1'b0};
        vecs[7]  = '{5'h00, 32'h0000_0001, 4'b0000, 1'b1, 4'h8, 1'b0, 4'b1110, 1'b1};
        vecs[8]  = '{5'h1F, 32'h0000_0002, 4'b1111, 1'b0, 4'h9, 1'b0, 4'b1110, 1'b1};
        vecs[9]  = '{5'h02, 32'h0000_0003, 4'b0101, 1'b1, 4'hA, 1'b0, 4'b1110, 1'b1};
        vecs[10] = '{5'h03, 32'h0000_0004, 4'b0001, 1'b1, 4'hB, 1'b1, 4'b0001, 1'b0};
        vecs[11] = '{5'h08, 32'h0000_0005, 4'b1110, 1'b1, 4'hC, 1'b1, 4'b0111, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_flags", flags, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_we", out_we, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Single words through an empty buffer with writeback always ready
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].result, vecs[i].nzcv, vecs[i].sf, vecs[i].rd);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].result);
            chk($sformatf("v%0d_out_rd", i), out_rd, vecs[i].rd);
            chk($sformatf("v%0d_out_we", i), out_we, vecs[i].exp_we);
            chk($sformatf("v%0d_flags", i), flags, vecs[i].exp_flags);
            chk($sformatf("v%0d_illegal", i), illegal, vecs[i].exp_ill);
`ifdef COND_EVAL_EN
            if (i == 4) begin
                cond = 4'hB;
                #1 chk("v4_cond_lt", cond_true, 1);
            end
`endif
            @(negedge clk);
            chk($sformatf("v%0d_drained", i), out_valid, 0);
            chk($sformatf("v%0d_illegal_end", i), illegal, 0);
        end

`ifdef COND_EVAL_EN
        // Flags now N=0 Z=1 C=1 V=1
        cc_exp = 16'h6A65;
        for (int k = 0; k < 16; k++) begin
            cond = k[3:0];
            #1 chk($sformatf("cond_%0h", k), cond_true, cc_exp[k]);
        end
`else
        cc_exp = '0;
`endif

        // Back-pressure: A,B accepted, C refused, drained in order
        out_ready = 1'b0;
        @(negedge clk);
        drive(5'h01, 32'hAAAA_0001, 4'b0000, 1'b0, 4'h1);
        @(negedge clk);
        drive(5'h01, 32'hBBBB_0002, 4'b0000, 1'b0, 4'h2);
        @(negedge clk);
        drive(5'h01, 32'hCCCC_0003, 4'b0000, 1'b0, 4'h3);
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_occupancy_full", occupancy, 2);
        chk("bp_head_A", out_data, 32'hAAAA_0001);
        @(negedge clk);
        chk("bp_occupancy_held", occupancy, 2);
        chk("bp_head_A_held", out_data, 32'hAAAA_0001);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_B", out_data, 32'hBBBB_0002);
        chk("bp_occ_one", occupancy, 1);
        @(negedge clk);
        chk("bp_empty", out_valid, 0);
        chk("bp_occ_zero", occupancy, 0);

        // Full with simultaneous push and pop: pop only
        out_ready = 1'b0;
        drive(5'h01, 32'h1111_0001, 4'b0000, 1'b0, 4'h4);
        @(negedge clk);
        drive(5'h01, 32'h2222_0002, 4'b0000, 1'b0, 4'h5);
        @(negedge clk);
        chk("pp_occ_full", occupancy, 2);
        drive(5'h01, 32'h3333_0003, 4'b0000, 1'b0, 4'h6);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pp_occ_one", occupancy, 1);
        chk("pp_head_second", out_data, 32'h2222_0002);
        chk("pp_head_rd", out_rd, 4'h5);
        @(negedge clk);
        chk("pp_empty", out_valid, 0);

        // Reset while full
        out_ready = 1'b0;
        drive(5'h03, 32'h5555_0001, 4'b1111, 1'b1, 4'h7);
        @(negedge clk);
        drive(5'h03, 32'h5555_0002, 4'b1111, 1'b1, 4'h8);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rf_occ_full", occupancy, 2);
        chk("rf_flags_set", flags, 4'b1111);
        #2 rst = 1'b0;
        #1;
        chk("rf_out_valid", out_valid, 0);
        chk("rf_occupancy", occupancy, 0);
        chk("rf_flags", flags, 0);
        chk("rf_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rf_in_ready", in_ready, 1);
        chk("rf_no_reappear", out_valid, 0);
        @(negedge clk);
        chk("rf_still_empty", occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
